instr_mem_fetch: RTL and testbench

//  Parametrised, loadable instruction memory with a valid/ready fetch port. Returns FETCH_W

---
 rtl/instr_mem_fetch.sv | 106 ++++++++++
 tb/tb_instr_mem_fetch.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_fetch.sv
// Loadable instruction memory with a valid/ready fetch port returning FETCH_W words per request.
// Optional feature: define IM_LOCK_EN to add a sticky write lock (lock_set input, load_err pulse).
module instr_mem_fetch #(
  parameter int WORD_W  = 32,
  parameter int DEPTH   = 64,
  parameter int FETCH_W = 2,
  parameter int ADDR_W  = $clog2(DEPTH),
  parameter int IDX_W   = $clog2(DEPTH/FETCH_W) + 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_load_en,
  input  logic [ADDR_W-1:0]         i_load_addr,
  input  logic [WORD_W-1:0]         i_load_data,
`ifdef IM_LOCK_EN
  input  logic                      i_lock_set,
`endif
  input  logic                      i_req_valid,
  output logic                      o_req_ready,
  input  logic [IDX_W-1:0]          i_req_idx,
  output logic                      o_rsp_valid,
  input  logic                      i_rsp_ready,
  output logic [FETCH_W*WORD_W-1:0] o_rsp_data,
  output logic                      o_rsp_err,
  output logic                      o_load_err
);

  localparam int NGROUPS = DEPTH / FETCH_W;
  localparam int FSHIFT  = $clog2(FETCH_W);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RESP = 1'b1;

  logic [WORD_W-1:0]         r_mem [DEPTH];
  logic [0:0]                r_state;
  logic [FETCH_W*WORD_W-1:0] r_rspData;
  logic                      r_rspErr;
  logic                      w_loadAct;
  logic                      w_accept;
  logic                      w_inRange;
  logic [ADDR_W-1:0]         w_base;
  logic [FETCH_W*WORD_W-1:0] w_fetch;

`ifdef IM_LOCK_EN
  logic r_lock;
  logic r_loadErr;

  // Lock is sticky until reset; a blocked write reports itself one cycle later.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lock    <= 1'b0;
      r_loadErr <= 1'b0;
    end else begin
      r_lock    <= r_lock | i_lock_set;
      r_loadErr <= i_load_en & r_lock;
    end
  end

  assign w_loadAct  = i_load_en & ~r_lock;
  assign o_load_err = r_loadErr;
`else
  assign w_loadAct  = i_load_en;
  assign o_load_err = 1'b0;
`endif

  assign o_req_ready = ~w_loadAct && ((r_state == S_IDLE) || i_rsp_ready);
  assign w_accept    = i_req_valid && o_req_ready;
  assign w_inRange   = (i_req_idx < IDX_W'(NGROUPS));
  assign w_base      = ADDR_W'(i_req_idx) << FSHIFT;

  // Lowest address lands in the most significant word of the response.
  always_comb begin
    w_fetch = '0;
    for (int k = 0; k < FETCH_W; k++) begin
      w_fetch[(FETCH_W-1-k)*WORD_W +: WORD_W] = r_mem[w_base + ADDR_W'(k)];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_loadAct) begin
      r_mem[i_load_addr] <= i_load_data;
    end
  end

  // Response register only changes on acceptance, so a stalled response stays frozen.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_rspData <= '0;
      r_rspErr  <= 1'b0;
    end else if (w_accept) begin
      r_state   <= S_RESP;
      r_rspData <= w_inRange ? w_fetch : '0;
      r_rspErr  <= ~w_inRange;
    end else if ((r_state == S_RESP) && i_rsp_ready) begin
      r_state <= S_IDLE;
    end
  end

  assign o_rsp_valid = (r_state == S_RESP);
  assign o_rsp_data  = r_rspData;
  assign o_rsp_err   = r_rspErr;

endmodule

// File: tb/tb_instr_mem_fetch.sv
// Directed self-checking bench for instr_mem_fetch (default 32-bit x 64 words, 2 words per fetch).
// Covers the IM_LOCK_EN lock path when that macro is defined for both files.
module tb_instr_mem_fetch;

  localparam int WORD_W  = 32;
  localparam int DEPTH   = 64;
  localparam int FETCH_W = 2;
  localparam int ADDR_W  = 6;
  localparam int IDX_W   = 6;

  logic                      clk = 1'b0;
  logic                      rstN;
  logic                      loadEn;
  logic [ADDR_W-1:0]         loadAddr;
  logic [WORD_W-1:0]         loadData;
  logic                      lockSet;
  logic                      reqValid;
  logic                      reqReady;
  logic [IDX_W-1:0]          reqIdx;
  logic                      rspValid;
  logic                      rspReady;
  logic [FETCH_W*WORD_W-1:0] rspData;
  logic                      rspErr;
  logic                      loadErr;

  int nCompared = 0;
  int nMismatch = 0;

  logic [ADDR_W-1:0] loadAddrTab [8];
  logic [WORD_W-1:0] loadDataTab [8];
  logic [63:0]       heldData;

  instr_mem_fetch #(
    .WORD_W (WORD_W),
    .DEPTH  (DEPTH),
    .FETCH_W(FETCH_W)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rstN),
    .i_load_en  (loadEn),
    .i_load_addr(loadAddr),
    .i_load_data(loadData),
`ifdef IM_LOCK_EN
    .i_lock_set (lockSet),
`endif
    .i_req_valid(reqValid),
    .o_req_ready(reqReady),
    .i_req_idx  (reqIdx),
    .o_rsp_valid(rspValid),
    .i_rsp_ready(rspReady),
    .o_rsp_data (rspData),
    .o_rsp_err  (rspErr),
    .o_load_err (loadErr)
  );

  always #5 clk = ~clk;

  // Advance one clock and land 2 time units after the edge, clear of it.
  task automatic applyStimulus();
    @(posedge clk);
    #2;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    nCompared++;
    assert (observed === expected)
    else begin
      nMismatch++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    lockSet  = 1'b0;
    loadEn   = 1'b0;
    loadAddr = '0;
    loadData = '0;
    reqValid = 1'b0;
    reqIdx   = '0;
    rspReady = 1'b1;
    rstN     = 1'b0;
    #1;
    checkOutput("reset_rsp_valid", 128'(rspValid), 128'd0);
    checkOutput("reset_rsp_data",  128'(rspData),  128'd0);
    checkOutput("reset_rsp_err",   128'(rspErr),   128'd0);
    checkOutput("reset_load_err",  128'(loadErr),  128'd0);
    #12;
    rstN = 1'b1;
    applyStimulus();
    checkOutput("idle_req_ready", 128'(reqReady), 128'd1);

    // Sweep all in-range groups of the cleared memory.
    for (int i = 0; i < 32; i++) begin
      reqValid = 1'b1;
      reqIdx   = IDX_W'(i);
      applyStimulus();
      checkOutput($sformatf("sweep_valid_%0d", i), 128'(rspValid), 128'd1);
      checkOutput($sformatf("sweep_data_%0d", i),  128'(rspData),  128'd0);
      checkOutput($sformatf("sweep_err_%0d", i),   128'(rspErr),   128'd0);
    end
    reqValid = 1'b0;
    applyStimulus();
    checkOutput("sweep_end_idle", 128'(rspValid), 128'd0);

    loadAddrTab = '{6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd62, 6'd63};
    loadDataTab = '{32'h11111111, 32'h22222222, 32'h00001E41, 32'h0000B141,
                    32'h33333333, 32'h44444444, 32'hAAAA0062, 32'hBBBB0063};
    for (int i = 0; i < 8; i++) begin
      loadEn   = 1'b1;
      loadAddr = loadAddrTab[i];
      loadData = loadDataTab[i];
      #1;
      checkOutput($sformatf("load_blocks_ready_%0d", i), 128'(reqReady), 128'd0);
      applyStimulus();
    end
    loadEn = 1'b0;

    reqValid = 1'b1;
    reqIdx   = 6'd2;
    applyStimulus();
    checkOutput("idx2_valid", 128'(rspValid), 128'd1);
    checkOutput("idx2_data",  128'(rspData),  128'h00001E41_0000B141);
    reqValid = 1'b0;
    applyStimulus();

    // Back-to-back groups 1, 2, 3.
    reqValid = 1'b1;
    reqIdx   = 6'd1;
    applyStimulus();
    checkOutput("b2b1_valid", 128'(rspValid), 128'd1);
    checkOutput("b2b1_data",  128'(rspData),  128'h11111111_22222222);
    reqIdx = 6'd2;
    applyStimulus();
    checkOutput("b2b2_valid", 128'(rspValid), 128'd1);
    checkOutput("b2b2_data",  128'(rspData),  128'h00001E41_0000B141);
    reqIdx = 6'd3;
    applyStimulus();
    checkOutput("b2b3_valid", 128'(rspValid), 128'd1);
    checkOutput("b2b3_data",  128'(rspData),  128'h33333333_44444444);

    rspReady = 1'b0;
    reqIdx   = 6'd0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput($sformatf("stall_req_ready_%0d", i), 128'(reqReady), 128'd0);
      checkOutput($sformatf("stall_valid_%0d", i),     128'(rspValid), 128'd1);
      checkOutput($sformatf("stall_data_%0d", i),      128'(rspData),  128'h33333333_44444444);
      applyStimulus();
    end
    rspReady = 1'b1;
    #1;
    checkOutput("unstall_req_ready", 128'(reqReady), 128'd1);
    applyStimulus();
    checkOutput("unstall_idx0_data", 128'(rspData), 128'd0);
    reqValid = 1'b0;
    applyStimulus();
    checkOutput("unstall_idle", 128'(rspValid), 128'd0);
    checkOutput("idle_holds_data", 128'(rspData), 128'd0);

    // Range boundaries.
    reqValid = 1'b1;
    reqIdx   = 6'd32;
    applyStimulus();
    checkOutput("idx32_err",  128'(rspErr),  128'd1);
    checkOutput("idx32_data", 128'(rspData), 128'd0);
    reqIdx = 6'd31;
    applyStimulus();
    checkOutput("idx31_err",  128'(rspErr),  128'd0);
    checkOutput("idx31_data", 128'(rspData), 128'hAAAA0062_BBBB0063);
    reqIdx = 6'd63;
    applyStimulus();
    checkOutput("idx63_err",  128'(rspErr),  128'd1);
    checkOutput("idx63_data", 128'(rspData), 128'd0);
    reqValid = 1'b0;
    applyStimulus();

    // Load collides with a request: the load wins, the request waits a cycle.
    loadEn   = 1'b1;
    loadAddr = 6'd8;
    loadData = 32'hCAFE0008;
    reqValid = 1'b1;
    reqIdx   = 6'd4;
    #1;
    checkOutput("collide_req_ready", 128'(reqReady), 128'd0);
    applyStimulus();
    checkOutput("collide_no_rsp", 128'(rspValid), 128'd0);
    loadEn = 1'b0;
    #1;
    checkOutput("after_collide_ready", 128'(reqReady), 128'd1);
    applyStimulus();
    checkOutput("collide_rsp_valid", 128'(rspValid), 128'd1);
    checkOutput("collide_rsp_data",  128'(rspData),  128'hCAFE0008_00000000);

    // A later load must not disturb the held response.
    reqValid = 1'b0;
    rspReady = 1'b0;
    loadEn   = 1'b1;
    loadAddr = 6'd9;
    loadData = 32'h12345678;
    applyStimulus();
    loadEn = 1'b0;
    heldData = rspData;
    checkOutput("held_after_load", 128'(heldData), 128'hCAFE0008_00000000);
    checkOutput("held_valid", 128'(rspValid), 128'd1);

    #2;
    rstN = 1'b0;
    #1;
    checkOutput("midresp_reset_valid", 128'(rspValid), 128'd0);
    checkOutput("midresp_reset_data",  128'(rspData),  128'd0);
    #2;
    rstN     = 1'b1;
    rspReady = 1'b1;
    reqValid = 1'b1;
    reqIdx   = 6'd4;
    applyStimulus();
    checkOutput("post_reset_valid", 128'(rspValid), 128'd1);
    checkOutput("post_reset_data",  128'(rspData),  128'd0);
    reqValid = 1'b0;
    applyStimulus();

    loadEn   = 1'b1;
    loadAddr = 6'd1;
    loadData = 32'h00C0FFEE;
    applyStimulus();
    loadEn = 1'b0;

`ifdef IM_LOCK_EN
    lockSet = 1'b1;
    applyStimulus();
    lockSet  = 1'b0;
    loadEn   = 1'b1;
    loadAddr = 6'd0;
    loadData = 32'hFFFFFFFF;
    #1;
    checkOutput("locked_req_ready", 128'(reqReady), 128'd1);
    applyStimulus();
    loadEn = 1'b0;
    checkOutput("locked_load_err_pulse", 128'(loadErr), 128'd1);
    applyStimulus();
    checkOutput("locked_load_err_clear", 128'(loadErr), 128'd0);
`else
    loadEn   = 1'b1;
    loadAddr = 6'd0;
    loadData = 32'h0000ABCD;
    applyStimulus();
    loadEn = 1'b0;
    checkOutput("nolock_load_err", 128'(loadErr), 128'd0);
`endif

    reqValid = 1'b1;
    reqIdx   = 6'd0;
    applyStimulus();
`ifdef IM_LOCK_EN
    checkOutput("final_idx0_data", 128'(rspData), 128'h00000000_00C0FFEE);
`else
    checkOutput("final_idx0_data", 128'(rspData), 128'h0000ABCD_00C0FFEE);
`endif
    reqValid = 1'b0;
    applyStimulus();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
